// File: rtl/debouncer_multi.sv
// Multi-channel switch debouncer: per-channel synchroniser, stability filter FSM,
// registered debounced level plus press, release and long-press one-cycle ticks.
module debouncer_multi #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 120,
    parameter int LONG_CYCLES = 1000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N_CH-1:0] sw_i,
    output logic [N_CH-1:0] db_level_o,
    output logic [N_CH-1:0] press_tick_o,
    output logic [N_CH-1:0] release_tick_o,
    output logic [N_CH-1:0] long_tick_o
);

    localparam int DW = $clog2(DB_CYCLES + 1);
    localparam int HW = (LONG_CYCLES > 0) ? $clog2(LONG_CYCLES + 1) : 1;

    // The level flips on the DB_CYCLES-th consecutive differing edge, i.e. when
    // the counter already holds DB_CYCLES-1.
    localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        PEND_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        PEND_LOW    = 2'd3
    } state_t;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   sw_s;
            state_t                 state_reg, state_next;
            logic [DW-1:0]          db_cnt_reg, db_cnt_next;
            logic [HW-1:0]          hold_cnt_reg, hold_cnt_next;
            logic [HW-1:0]          hold_step;
            logic                   long_hit;
            logic                   level_reg, level_next;
            logic                   press_reg, press_next;
            logic                   release_reg, release_next;
            logic                   long_reg, long_next;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], sw_i[gi]};
                end
            end

            assign sw_s = sync_reg[SYNC_STAGES-1];

            // With LONG_CYCLES = 0 the counter sits at HOLD_MAX = 0, so it never
            // advances and long_hit can never assert.
            assign hold_step = (hold_cnt_reg != HOLD_MAX) ? hold_cnt_reg + HW'(1) : hold_cnt_reg;
            assign long_hit  = (hold_cnt_reg != HOLD_MAX) && (hold_cnt_reg == HOLD_LAST);

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    state_reg    <= STABLE_LOW;
                    db_cnt_reg   <= '0;
                    hold_cnt_reg <= '0;
                    level_reg    <= 1'b0;
                    press_reg    <= 1'b0;
                    release_reg  <= 1'b0;
                    long_reg     <= 1'b0;
                end else begin
                    state_reg    <= state_next;
                    db_cnt_reg   <= db_cnt_next;
                    hold_cnt_reg <= hold_cnt_next;
                    level_reg    <= level_next;
                    press_reg    <= press_next;
                    release_reg  <= release_next;
                    long_reg     <= long_next;
                end
            end

            always_comb begin
                state_next    = state_reg;
                db_cnt_next   = db_cnt_reg;
                hold_cnt_next = hold_cnt_reg;
                level_next    = level_reg;
                press_next    = 1'b0;
                release_next  = 1'b0;
                long_next     = 1'b0;

                case (state_reg)
                    STABLE_LOW, PEND_HIGH: begin
                        hold_cnt_next = '0;
                        if (sw_s) begin
                            if (db_cnt_reg == DB_LAST) begin
                                state_next  = STABLE_HIGH;
                                db_cnt_next = '0;
                                level_next  = 1'b1;
                                press_next  = 1'b1;
                            end else begin
                                state_next  = PEND_HIGH;
                                db_cnt_next = db_cnt_reg + DW'(1);
                            end
                        end else begin
                            state_next  = STABLE_LOW;
                            db_cnt_next = '0;
                        end
                    end
                    STABLE_HIGH, PEND_LOW: begin
                        if (!sw_s && (db_cnt_reg == DB_LAST)) begin
                            // A release on the long-press edge suppresses the long tick.
                            state_next    = STABLE_LOW;
                            db_cnt_next   = '0;
                            hold_cnt_next = '0;
                            level_next    = 1'b0;
                            release_next  = 1'b1;
                        end else begin
                            hold_cnt_next = hold_step;
                            long_next     = long_hit;
                            if (!sw_s) begin
                                state_next  = PEND_LOW;
                                db_cnt_next = db_cnt_reg + DW'(1);
                            end else begin
                                state_next  = STABLE_HIGH;
                                db_cnt_next = '0;
                            end
                        end
                    end
                    default: begin
                        state_next    = STABLE_LOW;
                        db_cnt_next   = '0;
                        hold_cnt_next = '0;
                        level_next    = 1'b0;
                    end
                endcase
            end

            assign db_level_o[gi]     = level_reg;
            assign press_tick_o[gi]   = press_reg;
            assign release_tick_o[gi] = release_reg;
            assign long_tick_o[gi]    = long_reg;
        end
    endgenerate

endmodule

// File: doc/debouncer_multi.md
# debouncer_multi

Parametrised multi-channel switch debouncer, successor to the single-channel debouncer. Each of `N_CH` asynchronous switch inputs is synchronised, filtered by a per-channel stability counter, and reported as a debounced level plus one-cycle press, release and long-press ticks. It sits between board-level buttons or switches and the control logic, one instance per input bank.

## Interface
- `N_CH`, 4: number of independent channels, 1 or more.
- `SYNC_STAGES`, 2: synchroniser flop depth per channel, 2 or more.
- `DB_CYCLES`, 120: consecutive sampling edges a changed input must hold before it is accepted, 1 or more.
- `LONG_CYCLES`, 1000: edges after a press at which the long-press tick fires; 0 disables long-press.
- `clk_i` input 1: single clock; all logic on its rising edge.
- `rst_i` input 1: synchronous, active-high reset.
- `sw_i` input N_CH: raw asynchronous switch inputs, may bounce.
- `db_level_o` output N_CH: debounced level.
- `press_tick_o` output N_CH: 1-cycle pulse when the debounced level rises.
- `release_tick_o` output N_CH: 1-cycle pulse when the debounced level falls.
- `long_tick_o` output N_CH: 1-cycle pulse when the level has been high for `LONG_CYCLES` edges.

## Operation
- Channels are fully independent replicas; no shared state or arbitration between them.
- Synchroniser: `sw_i[c]` passes through `SYNC_STAGES` flops; the last stage is `sw_s[c]`.
- Per-channel FSM states:
  - STABLE_LOW: `db_level` = 0.
  - PEND_HIGH: `db_level` = 0, `sw_s` = 1, counting.
  - STABLE_HIGH: `db_level` = 1.
  - PEND_LOW: `db_level` = 1, `sw_s` = 0, counting.
- FSM transitions:
  - STABLE_x to PEND_y when `sw_s` differs from `db_level`.
  - PEND_y back to STABLE_x when `sw_s` equals `db_level` again.
  - PEND_y to STABLE_y when the counter reaches `DB_CYCLES`.
- Debounce counter `db_cnt`:
  - Increments on every edge where `sw_s` differs from `db_level`.
  - Cleared to 0 on any edge where they are equal.
  - Cleared when the level flips.
  - Width is `$clog2(DB_CYCLES+1)`.
- Hold counter `hold_cnt`:
  - Cleared on the edge `db_level` rises.
  - Increments on each later edge while `db_level` = 1, including in PEND_LOW, so release bounces do not restart it.
  - Saturates at `LONG_CYCLES`.
  - Width is `$clog2(LONG_CYCLES+1)`, minimum 1.
- `long_tick` fires once per press, on the edge `hold_cnt` becomes `LONG_CYCLES`. It never repeats and never fires when `LONG_CYCLES` = 0.
- Ticks and `db_level` are registered outputs; no combinational path from `sw_i` to any output.

## Timing
- Reset state: on any edge with `rst_i` = 1, all of the following are cleared:
  - synchroniser flops, `db_cnt` and `hold_cnt`;
  - FSM set to STABLE_LOW;
  - all outputs (`db_level_o`, `press_tick_o`, `release_tick_o`, `long_tick_o`) driven to 0.
- Reset mid-operation:
  - Any pending count is discarded.
  - No tick is produced on the reset edge, even if one was due.
  - An input held high through reset is treated as a fresh press after deassertion and needs the full latency.
- Latency: number edges so that edge 1 is the first to sample a new `sw_i` value, with `sw_i` stable from then on.
  - `sw_s` changes after edge `SYNC_STAGES`.
  - `db_level_o` flips, and `press_tick_o` or `release_tick_o` is high, after edge `SYNC_STAGES+DB_CYCLES` (122 with defaults).
  - The tick is high for exactly one cycle.
- Rejection: any `sw_s` excursion shorter than `DB_CYCLES` consecutive edges produces no level change and no tick.
- Long press: `long_tick_o` is high after the edge `LONG_CYCLES` edges after the press edge (press at edge P gives long tick after edge P+`LONG_CYCLES`).
- Simultaneous events: if the level falls on the same edge `hold_cnt` would reach `LONG_CYCLES`, the release wins. `release_tick` = 1 and `long_tick` = 0 on that edge.
- Press and release ticks on the same channel are at least `DB_CYCLES` edges apart.
- Multiple channels may tick on the same edge.

## Test plan
- Clean press and release (defaults, ch0):
  - Stimulus: raise `sw_i[0]`, hold 200 cycles, then drop it.
  - Required: one `press_tick_o[0]` after edge 122; `db_level_o[0]` = 1 until one `release_tick_o[0]` 122 edges after the drop; no other ticks.
- Bounce rejection (ch1):
  - Stimulus: 10 pulses of random high and low lengths, each in 12..119 cycles; end low.
  - Required: zero ticks on ch1; `db_level_o[1]` stays 0.
  - Then hold `sw_i[1]` high 130 cycles: exactly one press tick.
- Long press (`LONG_CYCLES` = 300):
  - Stimulus: hold `sw_i[2]` high 1000 cycles.
  - Required: `long_tick_o[2]` exactly once, 300 edges after `press_tick_o[2]`; no repeat.
  - With `LONG_CYCLES` = 0: no long tick at all.
- Release/long collision:
  - Stimulus: time the release so `db_level` falls on the edge `hold_cnt` would reach `LONG_CYCLES`.
  - Required: `release_tick` = 1 and `long_tick` = 0 on that edge.
  - Same stimulus one cycle later: long tick, then the release.
- Channel independence:
  - Stimulus: press ch0 and ch3 on the same cycle while ch1 bounces.
  - Required: ch0 and ch3 press ticks on the same edge; ch1 is silent.
- Reset mid-debounce:
  - Stimulus: assert `rst_i` for 2 cycles at cycle 60 of a press, keeping `sw_i` high.
  - Required: all outputs 0 during reset; press tick exactly 122 edges after the first post-reset edge.
- Every scenario runs under a 10,000-cycle watchdog; any tick pulse longer than 1 cycle is an error.
